// File: rtl/accel_rb_pkg.sv
// Shared definitions for the accelerator result read-back path.
// Provides the streamer state encoding, default bank geometry and the
// helper that sizes the word index counter.
package accel_rb_pkg;

  localparam int RB_NUM_WORDS = 8;
  localparam int RB_DW        = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } rb_state_e;

  // Width of the word index; never below one bit so the counter always exists.
  function automatic int rb_idx_width(input int num_words);
    return (num_words < 2) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/result_snapshot_bank.sv
// Snapshot register bank: NUM_WORDS x DW words captured in parallel on load.
// Ports: clk/rst (async active-low clear), load, din (flat bank),
//        rd_idx -> rd_data (combinational read mux, 0 for out-of-range index).
module result_snapshot_bank
  import accel_rb_pkg::*;
#(
  parameter int NUM_WORDS = RB_NUM_WORDS,
  parameter int DW        = RB_DW,
  parameter int IW        = rb_idx_width(NUM_WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [NUM_WORDS*DW-1:0] din,
  input  logic [IW-1:0]           rd_idx,
  output logic [DW-1:0]           rd_data
);

  logic [DW-1:0] mem [NUM_WORDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_WORDS; i++) mem[i] <= din[i*DW +: DW];
    end
  end

  // Compare-based mux so non-power-of-two bank sizes never index past the end.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (rd_idx == IW'(i)) rd_data = mem[i];
    end
  end

endmodule

// File: rtl/result_readback_streamer.sv
// Snapshots the result bank on start and streams it one word per valid/ready
// handshake; busy covers STREAM and DONE, done pulses once after the last word.
// Ports: clk, rst (async active-low), start, res_in, out_* stream, busy, done.
module result_readback_streamer
  import accel_rb_pkg::*;
#(
  parameter int NUM_WORDS = RB_NUM_WORDS,
  parameter int DW        = RB_DW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_WORDS*DW-1:0] res_in,
  output logic [DW-1:0]           out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = rb_idx_width(NUM_WORDS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_WORDS - 1);

  rb_state_e     state_q, state_nxt;
  logic [IW-1:0] idx_q, idx_nxt, idx_inc;
  logic [DW-1:0] out_data_nxt;
  logic          out_valid_nxt, out_last_nxt, busy_nxt, done_nxt;
  logic          load;
  logic          xfer, at_last;
  logic [DW-1:0] bank_rd_data;

  assign xfer    = out_valid & out_ready;
  assign at_last = (idx_q == IDX_LAST);
  assign idx_inc = idx_q + IW'(1);

  // The bank is read one word ahead so the registered out_data can be
  // refreshed on the same edge that completes the current transfer.
  result_snapshot_bank #(
    .NUM_WORDS (NUM_WORDS),
    .DW        (DW),
    .IW        (IW)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .din     (res_in),
    .rd_idx  (idx_inc),
    .rd_data (bank_rd_data)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      idx_q     <= idx_nxt;
      out_data  <= out_data_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_nxt = ST_STREAM;
      ST_STREAM: if (xfer && at_last) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    idx_nxt       = idx_q;
    out_data_nxt  = out_data;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    load          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // The bank loads on this same edge, so word 0 is taken straight
          // from the live inputs rather than from the bank.
          load          = 1'b1;
          idx_nxt       = '0;
          out_valid_nxt = 1'b1;
          out_data_nxt  = res_in[DW-1:0];
          out_last_nxt  = 1'b0;
        end
      end
      ST_STREAM: begin
        if (xfer) begin
          if (at_last) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            out_data_nxt  = '0;
          end else begin
            idx_nxt      = idx_inc;
            out_data_nxt = bank_rd_data;
            out_last_nxt = (idx_inc == IDX_LAST);
          end
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
        out_last_nxt  = 1'b0;
        out_data_nxt  = '0;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
    done_nxt = (state_nxt == ST_DONE);
  end

endmodule

// File: tb/tb_result_readback_streamer.sv
module tb_result_readback_streamer;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int MI = 0;  // model idle
  localparam int MS = 1;  // model streaming
  localparam int MD = 2;  // model done cycle

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             out_ready = 1'b0;
  logic [N*W-1:0]   res_in = '0;
  logic [W-1:0]     out_data;
  logic             out_valid, out_last, busy, done;

  typedef struct packed {
    logic [W-1:0] d;
    logic         l;
  } exp_t;

  exp_t q[$];
  int   mst = MI;
  int   mcnt = 0;
  int   rdy_mode = 0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  result_readback_streamer #(.NUM_WORDS(N), .DW(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .res_in    (res_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a start seen while idle captures the bank and queues all
  // words in order; each ready cycle while streaming consumes one word; the
  // cycle after the last word is the single done cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst  = MI;
      mcnt = 0;
      q.delete();
    end else begin
      case (mst)
        MI: if (start) begin
          for (int i = 0; i < N; i++) q.push_back({res_in[i*W +: W], (i == N-1)});
          mcnt = 0;
          mst  = MS;
        end
        MS: if (out_ready) begin
          mcnt++;
          if (mcnt == N) mst = MD;
        end
        default: mst = MI;
      endcase
    end
  end

  // Consumer ready pattern.
  always @(posedge clk) begin
    #1;
    cyc++;
    case (rdy_mode)
      1:       out_ready = (cyc % 3 == 0);
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // Monitor: compares the DUT against the model away from the clock edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_valid", 64'(out_valid), 0);
      chk("rst_data",  64'(out_data),  0);
      chk("rst_busy",  64'(busy),      0);
      chk("rst_done",  64'(done),      0);
    end else begin
      chk("valid", 64'(out_valid), 64'(mst == MS));
      chk("busy",  64'(busy),      64'(mst != MI));
      chk("done",  64'(done),      64'(mst == MD));
      if (mst == MS) begin
        if (q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL scoreboard_empty: DUT streaming with no expected word at %0t", $time);
        end else begin
          chk("data", 64'(out_data), 64'(q[0].d));
          chk("last", 64'(out_last), 64'(q[0].l));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (!out_valid) begin
        chk("idle_data", 64'(out_data), 0);
        chk("idle_last", 64'(out_last), 0);
      end
    end
  end

  task automatic load_words(input bit pattern);
    for (int i = 0; i < N; i++)
      res_in[i*W +: W] = pattern ? 32'hA000_0000 + 32'(i) : $urandom();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((mst != MI || q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: stream did not finish within 300 cycles", nm);
    end
  endtask

  task automatic wait_state(input int s, input string nm);
    int n = 0;
    while (mst != s && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: model state %0d not reached", nm, s);
    end
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("reset_out_valid", 64'(out_valid), 0);
    chk("reset_out_last",  64'(out_last),  0);
    chk("reset_busy",      64'(busy),      0);
    rst = 1'b1;
    tick();

    // Basic stream at full throughput.
    rdy_mode = 0;
    load_words(1'b1);
    pulse_start();
    wait_idle("basic");
    chk("basic_busy_after", 64'(busy), 0);

    // Backpressure 1,0,0 pattern, then random ready.
    rdy_mode = 1;
    load_words(1'b0);
    pulse_start();
    wait_idle("backpressure");
    rdy_mode = 2;
    repeat (3) begin
      load_words(1'b0);
      pulse_start();
      wait_idle("random_ready");
      repeat (int'($urandom_range(0, 2))) tick();
    end

    // Snapshot isolation: bank inputs overwritten right after start.
    rdy_mode = 0;
    load_words(1'b0);
    pulse_start();
    res_in = '1;
    wait_idle("snapshot");

    // Start pulses during STREAM (word 3) and during DONE are ignored.
    load_words(1'b0);
    pulse_start();
    repeat (2) tick();
    pulse_start();
    wait_state(MD, "busy_start");
    pulse_start();
    wait_idle("busy_start");
    repeat (3) tick();

    // Back-to-back: start in the first IDLE cycle after done.
    load_words(1'b0);
    pulse_start();
    wait_state(MD, "b2b");
    tick();
    load_words(1'b0);
    pulse_start();
    wait_idle("b2b");

    // Asynchronous reset mid-stream after word 4.
    rdy_mode = 0;
    load_words(1'b0);
    pulse_start();
    n = 0;
    while (mcnt < 4 && n < 50) begin
      tick();
      n++;
    end
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 0);
    chk("async_rst_busy",  64'(busy),      0);
    chk("async_rst_data",  64'(out_data),  0);
    chk("async_rst_last",  64'(out_last),  0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    load_words(1'b0);
    pulse_start();
    wait_idle("after_reset");
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/result_readback_streamer.md
Name: result_readback_streamer

Overview:
- Read side of the accelerator result registers.
- On a start pulse it snapshots a bank of NUM_WORDS parallel DW-bit result registers.
- It then streams the captured words, one per handshake, onto a valid/ready output toward the SoC bus/DMA bridge.
- It frees the compute datapath to overwrite its registers as soon as the snapshot is taken.

Parameters:
- NUM_WORDS, 8, number of result words captured and streamed; legal range >= 2.
- DW, 32, width of each result word.

Ports:
- clk  input  1  system clock; all state updates on posedge clk.
- rst  input  1  reset, asynchronous and active-low; rst=0 immediately forces reset state.
- start  input  1  single-cycle request to snapshot and stream; honoured only in IDLE.
- res_in  input  NUM_WORDS*DW  flat result bank; word i = res_in[i*DW +: DW].
- out_data  output  DW  current word being offered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  consumer accepts; transfer occurs when out_valid & out_ready at posedge.
- out_last  output  1  high with the final word (index NUM_WORDS-1).
- busy  output  1  high in SNAP-free STREAM and DONE states.
- done  output  1  one-cycle pulse after the final transfer.

Behaviour:
- Reset (rst=0, any time, including mid-stream):
  - state=IDLE, idx=0, snapshot regs=0.
  - out_data=0, out_valid=0, out_last=0, busy=0, done=0.
  - A partial stream is abandoned and is not resumed after reset release.
- States are IDLE, STREAM and DONE; all outputs are registered.
- IDLE:
  - start=1 sampled at edge k captures all NUM_WORDS words of res_in into snapshot regs at edge k, and sets idx=0.
  - State -> STREAM.
  - From edge k: out_valid=1, out_data=word0, busy=1.
- STREAM:
  - out_data = snapshot[idx]; out_last = (idx==NUM_WORDS-1).
  - If out_valid & out_ready and idx<NUM_WORDS-1: idx<=idx+1, and the next word is presented in the following cycle.
  - This sustains one word per cycle with out_ready held high.
  - If out_ready=0: out_data, out_last and out_valid are held stable; there is no retraction.
  - Transfer of the last word: out_valid<=0, out_last<=0, state -> DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then state -> IDLE with done=0 and busy=0.
- Stream timing:
  - Minimum latency from start sample to first valid word is 1 cycle (valid after edge k).
  - Full stream completes in NUM_WORDS cycles at full throughput, plus 1 DONE cycle.
- start is ignored in STREAM and DONE; no queuing. A start in the IDLE cycle right after DONE is accepted.
- res_in changes after the snapshot edge do not affect streamed data.
- idx counter width is $clog2(NUM_WORDS). It never wraps past NUM_WORDS-1 and is reset to 0 on every accepted start.
- out_data is 0 whenever out_valid=0.

Decomposition:
- Shared package (accel_rb_pkg):
  - state enum {IDLE, STREAM, DONE}.
  - Default constants RB_NUM_WORDS=8 and RB_DW=32.
  - Function for the idx width.
- One sub-module, result_snapshot_bank:
  - NUM_WORDS x DW registers with async active-low clear and a load enable.
  - Combinational read mux by idx.
- The FSM, counter and handshake stay in the top module.

Test Plan:
- Basic stream:
  - Stimulus: reset, then res_in words i = 32'hA000_0000+i (NUM_WORDS=8), start pulse, out_ready=1.
  - Response: 8 consecutive transfers A0000000..A0000007, out_last only with A0000007, done pulse the following cycle, busy low after.
- Backpressure:
  - Stimulus: out_ready toggling 1,0,0,1,...
  - Response: out_data/out_last held constant while ready=0, no word dropped or duplicated, order preserved.
- Snapshot isolation:
  - Stimulus: change res_in to all 32'hFFFF_FFFF one cycle after start.
  - Response: streamed data is still the pre-start values.
- Start while busy:
  - Stimulus: pulse start during STREAM word 3 and during DONE.
  - Response: ignored, exactly 8 transfers, single done pulse.
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously (between clock edges) after word 4.
  - Response: out_valid/busy/out_data go 0 immediately. After release, a new start streams from word 0 again.
- Back-to-back:
  - Stimulus: start in the first IDLE cycle after done.
  - Response: second stream accepted, first word valid 1 cycle later.
